// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multicycle fetch/decode/execute/writeback sequencer for the 16-bit CPU datapath.
// Latency: 3 cycles for ALU/store/branch/jump/JAL/NOP, 3+LOAD_WAIT cycles for loads.
// Backpressure: none by default; with MEM_WAIT_EN defined, MemReady stalls MEM_RD exit and MEM_WR completion.
module cpu_control_fsm #(
    parameter int REG_ADDR_W = 4,
    parameter int IMM_W      = 8,
    parameter int LOAD_WAIT  = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [15:0]           Instr,
    input  logic [4:0]            ALUFlags,
`ifdef MEM_WAIT_EN
    input  logic                  MemReady,
`endif
    output logic                  PCEn,
    output logic [1:0]            PCSel,
    output logic                  RegEn,
    output logic                  RAMEn,
    output logic                  Imm_s,
    output logic                  Signed,
    output logic                  RamAddrSelect,
    output logic                  LoadInSelect,
    output logic                  LinkSel,
    output logic [3:0]            ALUOpCode,
    output logic [REG_ADDR_W-1:0] RdestRegLoc,
    output logic [REG_ADDR_W-1:0] RsrcRegLoc,
    output logic [IMM_W-1:0]      Imm,
    output logic                  CarryIn,
    output logic [4:0]            Flags,
    output logic                  IllegalInstr
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_SH,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_ADV
    } state_t;

    // ALU operation codes presented on ALUOpCode
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_CMP = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_LSH = 4'b0111;
    localparam logic [3:0] ALU_RSH = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1010;

    // Major opcodes that are not ALU immediate forms
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    // Secondary codes in IR[7:4]
    localparam logic [3:0] EXT_NOP  = 4'b0000;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_LSH  = 4'b0100;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_JAL  = 4'b1000;
    localparam logic [3:0] EXT_JCND = 4'b1100;

    // Load wait-counter limits; the counter counts MEM_RD cycles already spent
    localparam logic [3:0] LW_MAX = 4'(LOAD_WAIT);
    localparam logic [3:0] LW_M1  = 4'(LOAD_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  flags_q, flags_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic [3:0]  ir_op, ir_a, ir_ext, ir_b;
    logic [3:0]  alu_key;
    logic [3:0]  alu_op;
    logic        alu_sets_flags;
    state_t      dec_next;
    logic        dec_illegal;
    logic        cond_true;
    logic        mem_ready;
    logic [IMM_W-1:0] imm_sx, imm_zx, imm_sh;

    assign ir_op  = ir_q[15:12];
    assign ir_a   = ir_q[11:8];
    assign ir_ext = ir_q[7:4];
    assign ir_b   = ir_q[3:0];

    assign imm_sx = IMM_W'($signed(ir_q[7:0]));
    assign imm_zx = IMM_W'(ir_q[7:0]);
    assign imm_sh = IMM_W'(ir_q[3:0]);

`ifdef MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // True when a 4-bit code names one of the ALU register/immediate instructions
    function automatic logic is_alu_code(input logic [3:0] code);
        case (code)
            4'b0101, 4'b0110, 4'b0111, 4'b1110,
            4'b1001, 4'b1010, 4'b1011,
            4'b0001, 4'b0010, 4'b0011: is_alu_code = 1'b1;
            default:                   is_alu_code = 1'b0;
        endcase
    endfunction

    // ALU operand key: immediate forms carry the code in the major opcode, R-type in ext
    assign alu_key = (state_q == S_EXEC_I) ? ir_op : ir_ext;

    // Map the instruction code to an ALU operation and note whether it captures flags
    always_comb begin
        alu_op         = ALU_ADD;
        alu_sets_flags = 1'b0;
        case (alu_key)
            4'b0101, 4'b0110, 4'b0111: begin alu_op = ALU_ADD; alu_sets_flags = 1'b1; end
            4'b1001, 4'b1010:          begin alu_op = ALU_SUB; alu_sets_flags = 1'b1; end
            4'b1011:                   begin alu_op = ALU_CMP; alu_sets_flags = 1'b1; end
            4'b0001:                   alu_op = ALU_AND;
            4'b0010:                   alu_op = ALU_OR;
            4'b0011:                   alu_op = ALU_XOR;
            4'b1110:                   alu_op = ALU_MUL;
            default:                   alu_op = ALU_ADD;
        endcase
    end

    // Classify the held instruction; anything unrecognised advances the PC and flags illegal
    always_comb begin
        dec_next    = S_ADV;
        dec_illegal = 1'b1;
        case (ir_op)
            OP_RTYPE: begin
                if (ir_ext == EXT_NOP) begin
                    dec_illegal = 1'b0;
                end else if (is_alu_code(ir_ext)) begin
                    dec_next    = S_EXEC_R;
                    dec_illegal = 1'b0;
                end
            end
            OP_SHIFT: begin
                if (ir_ext == EXT_LSH || ir_ext[3:1] == 3'b000) begin
                    dec_next    = S_EXEC_SH;
                    dec_illegal = 1'b0;
                end
            end
            OP_MEM: begin
                case (ir_ext)
                    EXT_LOAD: begin dec_next = S_MEM_RD; dec_illegal = 1'b0; end
                    EXT_STOR: begin dec_next = S_MEM_WR; dec_illegal = 1'b0; end
                    EXT_JCND: begin dec_next = S_JUMP;   dec_illegal = 1'b0; end
                    EXT_JAL:  begin dec_next = S_JAL;    dec_illegal = 1'b0; end
                    default:  begin dec_next = S_ADV;    dec_illegal = 1'b1; end
                endcase
            end
            OP_BCOND: begin
                dec_next    = S_BRANCH;
                dec_illegal = 1'b0;
            end
            default: begin
                if (is_alu_code(ir_op)) begin
                    dec_next    = S_EXEC_I;
                    dec_illegal = 1'b0;
                end
            end
        endcase
    end

    // Branch/jump condition from IR[11:8] against the registered flags {C,L,F,Z,N}
    always_comb begin
        cond_true = 1'b0;
        case (ir_a)
            4'b0000: cond_true =  flags_q[1];
            4'b0001: cond_true = !flags_q[1];
            4'b0010: cond_true =  flags_q[4];
            4'b0011: cond_true = !flags_q[4];
            4'b0100: cond_true =  flags_q[3];
            4'b0101: cond_true = !flags_q[3];
            4'b0110: cond_true =  flags_q[0];
            4'b0111: cond_true = !flags_q[0];
            4'b1000: cond_true =  flags_q[2];
            4'b1001: cond_true = !flags_q[2];
            4'b1010: cond_true = !flags_q[3] && !flags_q[1];
            4'b1011: cond_true =  flags_q[3] ||  flags_q[1];
            4'b1100: cond_true = !flags_q[0] && !flags_q[1];
            4'b1101: cond_true =  flags_q[0] ||  flags_q[1];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Next-state, datapath controls and register updates for the current state
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        flags_d       = flags_q;
        wait_cnt_d    = '0;
        PCEn          = 1'b0;
        PCSel         = 2'b00;
        RegEn         = 1'b0;
        RAMEn         = 1'b0;
        Imm_s         = 1'b0;
        Signed        = 1'b0;
        RamAddrSelect = 1'b0;
        LoadInSelect  = 1'b0;
        LinkSel       = 1'b0;
        ALUOpCode     = ALU_ADD;
        RdestRegLoc   = '0;
        RsrcRegLoc    = '0;
        Imm           = '0;
        IllegalInstr  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = Instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = dec_next;
            end
            S_EXEC_R: begin
                PCEn        = 1'b1;
                RegEn       = (alu_op != ALU_CMP);
                ALUOpCode   = alu_op;
                RdestRegLoc = REG_ADDR_W'(ir_a);
                RsrcRegLoc  = REG_ADDR_W'(ir_b);
                if (alu_sets_flags) flags_d = ALUFlags;
                state_d     = S_FETCH;
            end
            S_EXEC_I: begin
                PCEn        = 1'b1;
                RegEn       = (alu_op != ALU_CMP);
                Imm_s       = 1'b1;
                Signed      = (ir_op != EXT_ADDU);
                ALUOpCode   = alu_op;
                RdestRegLoc = REG_ADDR_W'(ir_a);
                Imm         = (ir_op != EXT_ADDU) ? imm_sx : imm_zx;
                if (alu_sets_flags) flags_d = ALUFlags;
                state_d     = S_FETCH;
            end
            S_EXEC_SH: begin
                PCEn        = 1'b1;
                RegEn       = 1'b1;
                RdestRegLoc = REG_ADDR_W'(ir_a);
                if (ir_ext == EXT_LSH) begin
                    ALUOpCode  = ALU_LSH;
                    RsrcRegLoc = REG_ADDR_W'(ir_b);
                end else begin
                    // Immediate shift: bit 4 picks direction, amount is IR[3:0]
                    ALUOpCode = ir_q[4] ? ALU_RSH : ALU_LSH;
                    Imm_s     = 1'b1;
                    Imm       = imm_sh;
                end
                state_d     = S_FETCH;
            end
            S_MEM_RD: begin
                RamAddrSelect = 1'b1;
                RsrcRegLoc    = REG_ADDR_W'(ir_b);
                if (wait_cnt_q >= LW_M1 && mem_ready) begin
                    state_d = S_LOAD_WB;
                end else begin
                    wait_cnt_d = (wait_cnt_q >= LW_MAX) ? LW_MAX : wait_cnt_q + 4'd1;
                end
            end
            S_LOAD_WB: begin
                PCEn          = 1'b1;
                RegEn         = 1'b1;
                LoadInSelect  = 1'b1;
                RamAddrSelect = 1'b1;
                RdestRegLoc   = REG_ADDR_W'(ir_a);
                RsrcRegLoc    = REG_ADDR_W'(ir_b);
                state_d       = S_FETCH;
            end
            S_MEM_WR: begin
                RAMEn         = 1'b1;
                RamAddrSelect = 1'b1;
                RdestRegLoc   = REG_ADDR_W'(ir_a);
                RsrcRegLoc    = REG_ADDR_W'(ir_b);
                PCEn          = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                PCEn    = 1'b1;
                Signed  = 1'b1;
                Imm     = imm_sx;
                PCSel   = cond_true ? 2'b01 : 2'b00;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCEn       = 1'b1;
                RsrcRegLoc = REG_ADDR_W'(ir_b);
                PCSel      = cond_true ? 2'b10 : 2'b00;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                // Link register written with PC+1 on the same edge the PC jumps
                PCEn        = 1'b1;
                RegEn       = 1'b1;
                LinkSel     = 1'b1;
                PCSel       = 2'b10;
                RdestRegLoc = REG_ADDR_W'(ir_a);
                RsrcRegLoc  = REG_ADDR_W'(ir_b);
                state_d     = S_FETCH;
            end
            S_ADV: begin
                PCEn         = 1'b1;
                IllegalInstr = dec_illegal;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign Flags   = flags_q;
    assign CarryIn = flags_q[4];

    // State, instruction, flags and wait-counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            flags_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            flags_q    <= flags_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed table, hand sequences and random instructions against a reference model.
// Latency: each instruction is followed cycle by cycle from FETCH through its final state.
// Backpressure: MemReady (when present) is held high.
module tb_cpu_control_fsm;

    localparam int LW = 3;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Instr;
    logic [4:0]  ALUFlags;
`ifdef MEM_WAIT_EN
    logic        MemReady = 1'b1;
`endif
    logic        PCEn, RegEn, RAMEn, Imm_s, Signed, RamAddrSelect, LoadInSelect, LinkSel;
    logic        CarryIn, IllegalInstr;
    logic [1:0]  PCSel;
    logic [3:0]  ALUOpCode, RdestRegLoc, RsrcRegLoc;
    logic [7:0]  Imm;
    logic [4:0]  Flags;

    cpu_control_fsm #(.REG_ADDR_W(4), .IMM_W(8), .LOAD_WAIT(LW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
`ifdef MEM_WAIT_EN
        .MemReady(MemReady),
`endif
        .PCEn(PCEn), .PCSel(PCSel), .RegEn(RegEn), .RAMEn(RAMEn), .Imm_s(Imm_s), .Signed(Signed),
        .RamAddrSelect(RamAddrSelect), .LoadInSelect(LoadInSelect), .LinkSel(LinkSel),
        .ALUOpCode(ALUOpCode), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc), .Imm(Imm),
        .CarryIn(CarryIn), .Flags(Flags), .IllegalInstr(IllegalInstr)
    );

    typedef struct packed {
        logic       pcen;
        logic [1:0] pcsel;
        logic       regen;
        logic       ramen;
        logic       imm_s;
        logic       sgn;
        logic       ras;
        logic       lis;
        logic       link;
        logic [3:0] aluop;
        logic [3:0] rdest;
        logic [3:0] rsrc;
        logic [7:0] imm;
        logic       cin;
        logic [4:0] flags;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [15:0] ins;
        logic [4:0]  af;
        outs_t       e;
        logic [4:0]  fa;
    } vec_t;

    typedef enum int {K_ALU_R, K_ALU_I, K_SH_R, K_SH_I, K_LOAD, K_STOR, K_JCOND, K_JAL, K_BCOND, K_NOP, K_ILL} kind_t;

    outs_t dut_o;
    assign dut_o = {PCEn, PCSel, RegEn, RAMEn, Imm_s, Signed, RamAddrSelect, LoadInSelect, LinkSel,
                    ALUOpCode, RdestRegLoc, RsrcRegLoc, Imm, CarryIn, Flags, IllegalInstr};

    int n_pass = 0;
    int n_checks = 0;
    logic [4:0] mflags = '0;

    // ALU operation per instruction code, -1 where the code is not an ALU instruction
    int alu_of [16] = '{-1, 3, 4, 5, -1, 0, 0, 0, -1, 1, 1, 2, -1, -1, 10, -1};
    int alu_list [10] = '{5, 6, 7, 14, 9, 10, 11, 1, 2, 3};
    int sh_ext [3] = '{4, 0, 1};
    int mem_ext [4] = '{0, 4, 12, 8};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input outs_t got, input outs_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic outs_t mk(input logic pcen, input logic [1:0] pcsel, input logic regen,
                                 input logic ramen, input logic imm_s, input logic sgn, input logic ras,
                                 input logic lis, input logic link, input logic [3:0] aluop,
                                 input logic [3:0] rdest, input logic [3:0] rsrc, input logic [7:0] imm,
                                 input logic ill);
        outs_t o;
        o = '0;
        o.pcen = pcen; o.pcsel = pcsel; o.regen = regen; o.ramen = ramen; o.imm_s = imm_s;
        o.sgn = sgn; o.ras = ras; o.lis = lis; o.link = link; o.aluop = aluop;
        o.rdest = rdest; o.rsrc = rsrc; o.imm = imm; o.ill = ill;
        return o;
    endfunction

    function automatic outs_t withf(input outs_t o);
        outs_t r;
        r = o;
        r.flags = mflags;
        r.cin = mflags[4];
        return r;
    endfunction

    function automatic outs_t idle();
        return withf('0);
    endfunction

    function automatic bit cond_ok(input logic [3:0] cc, input logic [4:0] f);
        bit c, l, fl, z, n;
        {c, l, fl, z, n} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return fl;
            4'd9:  return !fl;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic kind_t classify(input logic [15:0] ins);
        logic [3:0] op, ext;
        op = ins[15:12];
        ext = ins[7:4];
        if (op == 4'h0) begin
            if (ext == 4'h0) return K_NOP;
            return (alu_of[ext] >= 0) ? K_ALU_R : K_ILL;
        end
        if (op == 4'h8) begin
            if (ext == 4'h4) return K_SH_R;
            if (ext <= 4'h1) return K_SH_I;
            return K_ILL;
        end
        if (op == 4'h4) begin
            case (ext)
                4'h0:    return K_LOAD;
                4'h4:    return K_STOR;
                4'hC:    return K_JCOND;
                4'h8:    return K_JAL;
                default: return K_ILL;
            endcase
        end
        if (op == 4'hC) return K_BCOND;
        return (alu_of[op] >= 0) ? K_ALU_I : K_ILL;
    endfunction

    // ADD, SUB and CMP families capture ALUFlags; everything else keeps the flags
    function automatic bit sets_flags(input logic [15:0] ins);
        kind_t k;
        int code;
        k = classify(ins);
        if (k == K_ALU_R) code = alu_of[ins[7:4]];
        else if (k == K_ALU_I) code = alu_of[ins[15:12]];
        else return 1'b0;
        return code <= 2;
    endfunction

    function automatic int model_len(input logic [15:0] ins);
        return (classify(ins) == K_LOAD) ? LW + 1 : 1;
    endfunction

    // Expected outputs in execute-phase cycle p (0 = third cycle of the instruction)
    function automatic outs_t model_exec(input logic [15:0] ins, input int p);
        logic [3:0] a, b;
        int code;
        outs_t o;
        a = ins[11:8];
        b = ins[3:0];
        o = '0;
        case (classify(ins))
            K_ALU_R: begin
                code = alu_of[ins[7:4]];
                o = mk(1, 0, code != 2, 0, 0, 0, 0, 0, 0, 4'(code), a, b, 8'h00, 0);
            end
            K_ALU_I: begin
                code = alu_of[ins[15:12]];
                o = mk(1, 0, code != 2, 0, 1, ins[15:12] != 4'h6, 0, 0, 0, 4'(code), a, 4'h0, ins[7:0], 0);
            end
            K_SH_R:  o = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd7, a, b, 8'h00, 0);
            K_SH_I:  o = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, ins[4] ? 4'd8 : 4'd7, a, 4'h0, {4'h0, b}, 0);
            K_LOAD: begin
                if (p < LW) o = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 4'h0, b, 8'h00, 0);
                else        o = mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 4'd0, a, b, 8'h00, 0);
            end
            K_STOR:  o = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 4'd0, a, b, 8'h00, 0);
            K_JCOND: o = mk(1, cond_ok(a, mflags) ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'h0, b, 8'h00, 0);
            K_JAL:   o = mk(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 4'd0, a, b, 8'h00, 0);
            K_BCOND: o = mk(1, cond_ok(a, mflags) ? 2'b01 : 2'b00, 0, 0, 0, 1, 0, 0, 0, 4'd0, 4'h0, 4'h0, ins[7:0], 0);
            K_NOP:   o = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'h0, 4'h0, 8'h00, 0);
            default: o = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'h0, 4'h0, 8'h00, 1);
        endcase
        return withf(o);
    endfunction

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Run one instruction starting in FETCH; garbage on Instr after FETCH must be ignored
    task automatic run_instr(input logic [15:0] ins, input logic [4:0] af);
        Instr = ins;
        ALUFlags = af;
        #1 check($sformatf("fetch_%h", ins), dut_o, idle());
        step();
        Instr = 16'($urandom);
        #1 check($sformatf("decode_%h", ins), dut_o, idle());
        for (int p = 0; p < model_len(ins); p++) begin
            step();
            Instr = 16'($urandom);
            #1 check($sformatf("exec%0d_%h", p, ins), dut_o, model_exec(ins, p));
        end
        if (sets_flags(ins)) mflags = af;
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        Instr = v.ins;
        ALUFlags = v.af;
        #1 check($sformatf("vec%0d_fetch", idx), dut_o, idle());
        step();
        Instr = 16'($urandom);
        #1 check($sformatf("vec%0d_decode", idx), dut_o, idle());
        step();
        #1 check($sformatf("vec%0d_exec_%h", idx, v.ins), dut_o, withf(v.e));
        mflags = v.fa;
        step();
    endtask

    vec_t tbl [18];
    logic [15:0] rins;
    logic [4:0]  raf;

    initial begin
        tbl[0]  = '{16'h0355, 5'b10000, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd3, 4'd5, 8'h00, 0), 5'b10000};
        tbl[1]  = '{16'hB2FF, 5'b00010, mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0010, 4'd2, 4'd0, 8'hFF, 0), 5'b00010};
        tbl[2]  = '{16'hC005, 5'b10101, mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'h05, 0), 5'b00010};
        tbl[3]  = '{16'hC105, 5'b10101, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'h05, 0), 5'b00010};
        tbl[4]  = '{16'h4E87, 5'b11111, mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 4'd14, 4'd7, 8'h00, 0), 5'b00010};
        tbl[5]  = '{16'hF000, 5'b11111, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'h00, 1), 5'b00010};
        tbl[6]  = '{16'h6180, 5'b01001, mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 4'b0000, 4'd1, 4'd0, 8'h80, 0), 5'b01001};
        tbl[7]  = '{16'h8413, 5'b10110, mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 4'b1000, 4'd4, 4'd0, 8'h03, 0), 5'b01001};
        tbl[8]  = '{16'h8442, 5'b10110, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0111, 4'd4, 4'd2, 8'h00, 0), 5'b01001};
        tbl[9]  = '{16'h01E2, 5'b11111, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010, 4'd1, 4'd2, 8'h00, 0), 5'b01001};
        tbl[10] = '{16'h4EC9, 5'b00000, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd9, 8'h00, 0), 5'b01001};
        tbl[11] = '{16'h4AC9, 5'b00000, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd9, 8'h00, 0), 5'b01001};
        tbl[12] = '{16'h4346, 5'b00000, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 4'b0000, 4'd3, 4'd6, 8'h00, 0), 5'b01001};
        tbl[13] = '{16'h0000, 5'b11111, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'h00, 0), 5'b01001};
        tbl[14] = '{16'hCDF0, 5'b00000, mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'hF0, 0), 5'b01001};
        tbl[15] = '{16'h00F0, 5'b11111, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'd0, 4'd0, 8'h00, 1), 5'b01001};
        tbl[16] = '{16'h05A6, 5'b00000, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 4'd5, 4'd6, 8'h00, 0), 5'b00000};
        tbl[17] = '{16'h1A3C, 5'b11111, mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 4'b0011, 4'd10, 4'd0, 8'h3C, 0), 5'b00000};

        Reset_n = 1'b0;
        Instr = 16'hFFFF;
        ALUFlags = 5'b11111;
        #1 check("reset_state", dut_o, idle());
        step();
        step();
        Reset_n = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // LOAD R1,[R4]: three MEM_RD cycles then LOAD_WB in cycle 6
        Instr = 16'h4104;
        ALUFlags = 5'b10101;
        #1 check("load_fetch", dut_o, idle());
        step();
        Instr = 16'h0355;
        #1 check("load_decode", dut_o, idle());
        for (int c = 0; c < 3; c++) begin
            step();
            #1 check($sformatf("load_memrd%0d", c), dut_o, withf(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd4, 8'h00, 0)));
        end
        step();
        #1 check("load_wb", dut_o, withf(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 4'd0, 4'd1, 4'd4, 8'h00, 0)));
        step();

        // Reset asserted during LOAD_WB clears everything at once
        run_instr(16'h0355, 5'b11111);
        Instr = 16'h4104;
        #1;
        for (int c = 0; c < 5; c++) step();
        #1 check("rst_pre_wb", dut_o, withf(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 4'd0, 4'd1, 4'd4, 8'h00, 0)));
        Reset_n = 1'b0;
        mflags = '0;
        #1 check("rst_async_clear", dut_o, idle());
        step();
        #1 check("rst_hold", dut_o, idle());
        Reset_n = 1'b1;
        run_instr(16'h0355, 5'b00110);

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: rins = {4'h0, 4'($urandom), 4'(alu_list[$urandom_range(0, 9)]), 4'($urandom)};
                1: rins = {4'(alu_list[$urandom_range(0, 9)]), 12'($urandom)};
                2: rins = {4'h8, 4'($urandom), 4'(sh_ext[$urandom_range(0, 2)]), 4'($urandom)};
                3: rins = {4'h4, 4'($urandom), 4'(mem_ext[$urandom_range(0, 3)]), 4'($urandom)};
                4: rins = {4'hC, 12'($urandom)};
                default: rins = 16'($urandom);
            endcase
            raf = 5'($urandom);
            run_instr(rins, raf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Parameterised multicycle control unit for the 16-bit CPU datapath: fetch, decode, execute and writeback sequencing for the ALU, load/store, branch and jump instructions.
- Adds conditional branches/jumps, JAL linking, an internal flags register and configurable memory read latency.
- Sits between instruction RAM output, ALU flags and the register file, PC and RAM enables.
- All state updates occur on the rising edge of Clk.

Parameters:
- REG_ADDR_W, 4: width of register-select outputs; instruction fields [11:8] and [3:0] are zero-extended to this width.
- IMM_W, 8: width of the Imm output; instr[7:0] is sign- or zero-extended per Signed.
- LOAD_WAIT, 1: number of MEM_RD cycles (1..15) before load writeback.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Instr  in  16  instruction word from memory
- ALUFlags  in  5  {C,L,F,Z,N} from the ALU
- PCEn  out  1  PC update strobe
- PCSel  out  2  00 PC+1, 01 PC+disp (Imm), 10 PC<-Rtarget
- RegEn, RAMEn  out  1 each  register-file write / RAM write
- Imm_s, Signed  out  1 each  select immediate / sign-extend it
- RamAddrSelect, LoadInSelect, LinkSel  out  1 each  RAM address from Raddr / reg-file input from RAM / reg-file input PC+1
- ALUOpCode  out  4  ADD 0000, SUB 0001, CMP 0010, AND 0011, OR 0100, XOR 0101, LSH 0111, RSH 1000, MUL 1010
- RdestRegLoc, RsrcRegLoc  out  REG_ADDR_W  register selects
- Imm  out  IMM_W  extended immediate / displacement
- CarryIn  out  1  stored C flag for ADDC/SUBC
- Flags  out  5  flags register
- IllegalInstr  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- Reset (async, Reset_n=0): state FETCH, IR=0, Flags=0, wait counter=0. All outputs 0 and deasserted; no X values are driven in any state.
- States and transitions:
  - FETCH -> DECODE. IR<=Instr at the end of FETCH.
  - DECODE -> EXEC_R | EXEC_I | EXEC_SH | MEM_RD | MEM_WR | BRANCH | JUMP | JAL | ADV.
  - MEM_RD holds for LOAD_WAIT cycles, then -> LOAD_WB.
  - Every other state -> FETCH.
- Decode (op=IR[15:12], ext=IR[7:4]):
  - op 0000 is R-type by ext: ADD 0101, ADDU 0110, ADDC 0111, MUL 1110, SUB 1001, SUBC 1010, CMP 1011, AND 0001, OR 0010, XOR 0011; ext 0000 is NOP -> ADV.
  - The same op values at [15:12] are the immediate forms -> EXEC_I.
  - op 1000 with ext 0100 is LSH reg. op 1000 with ext 000s is LSHI, where s=1 means right shift and the shift amount is IR[3:0].
  - op 0100: LOAD ext 0000, STOR ext 0100, Jcond ext 1100, JAL ext 1000.
  - op 1100 is Bcond with 8-bit signed displacement.
  - Anything else -> ADV with IllegalInstr=1.
- EXEC_R / EXEC_I / EXEC_SH: RegEn=1 except for CMP, plus PCEn=1, PCSel=00.
  - EXEC_I sets Imm_s=1. Signed=0 only for ADDUI, otherwise 1.
  - LSHI selects LSH or RSH from s.
- Flags<=ALUFlags on the EXEC edge for ADD, ADDU, ADDC, SUB, SUBC, CMP (R and I forms) only. All other instructions leave Flags unchanged.
- CarryIn = Flags[4] in all states.
- MEM_RD: RamAddrSelect=1, RsrcRegLoc=addr reg.
- LOAD_WB: RegEn=1, LoadInSelect=1, RamAddrSelect=1, PCEn=1.
- MEM_WR: RAMEn=1, RamAddrSelect=1, PCEn=1.
- Condition on IR[11:8]:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N
  - FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never
  - Evaluated on the registered Flags, not on ALUFlags.
- BRANCH: PCEn=1, Imm=sign-extended disp, Signed=1; PCSel=01 if taken, else 00.
- JUMP: PCEn=1, RsrcRegLoc=IR[3:0]; PCSel=10 if taken, else 00.
- JAL: RegEn=1, LinkSel=1, RdestRegLoc=IR[11:8], PCSel=10, PCEn=1 (link and jump in the same edge).
- ADV: PCEn=1, PCSel=00.
- Latency: ALU/store/branch/jump/JAL/NOP = 3 cycles; load = 3+LOAD_WAIT cycles.
- Boundaries:
  - Reset mid-instruction aborts with no further enables.
  - Instr changes outside FETCH are ignored.
  - The wait counter saturates at LOAD_WAIT and is cleared on leaving MEM_RD.

Optional Feature:
MEM_WAIT_EN
- Defined:
  - Adds input MemReady (1 bit).
  - MEM_RD leaves only when the LOAD_WAIT count is reached and MemReady=1.
  - MEM_WR holds with RAMEn=1 and PCEn=0 until MemReady=1, then asserts PCEn for that cycle.
- Undefined: no port and fixed latency as above.

Test Plan:
- Reset_n low mid-LOAD_WB -> all outputs 0 immediately; next FETCH begins 1 cycle after release; Flags=0.
- ADD R3,R5 (0x0355) with ALUFlags=5'b10000 -> EXEC cycle 3: RegEn=1, ALUOpCode=0000, Rdest=3, Rsrc=5; Flags=10000 after; CarryIn=1.
- CMPI R2,#-1 (0xB2FF) -> RegEn=0, Imm=8'hFF, Signed=1, ALUOpCode=0010; Flags captured.
- LOAD R1,[R4] (0x4104) with LOAD_WAIT=3 -> MEM_RD for 3 cycles; LOAD_WB on cycle 6 with RegEn=1, LoadInSelect=1.
- With Flags Z=1: BEQ +5 (0xC005) -> PCSel=01, Imm=5. BNE (0xC105) -> PCSel=00. Both PCEn=1 in cycle 3.
- JAL R14,R7 (0x4E87) -> RegEn=1, LinkSel=1, PCSel=10, Rdest=14, Rsrc=7. Opcode 0xF000 -> IllegalInstr pulse and PC+1.
